// File: rtl/core_launcher.sv
`default_nettype none
// ============================================================================
// Module   : core_launcher
// Purpose  : Host-side job sequencer: load image, launch core, time the run,
//            unload a fixed result window.
// Revision : 1.0 - initial release
// ============================================================================
module core_launcher #(
  parameter int AW      = 8,
  parameter int RD_BASE = 64,
  parameter int RD_LEN  = 8,
  parameter int CW      = 16,
  parameter int TIMEOUT = 4095
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  input  logic          ld_last,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_dat_in,
  input  logic [7:0]    mem_dat_out,
  output logic          req,
  input  logic          done,
  output logic          rs_valid,
  input  logic          rs_ready,
  output logic [7:0]    rs_data,
  output logic          rs_last,
  output logic          busy,
  output logic [CW-1:0] cycles,
  output logic          timeout_err
);

  localparam logic [AW-1:0] BASE_C     = AW'(RD_BASE);
  localparam logic [AW-1:0] LAST_IDX_C = AW'(RD_LEN - 1);
  localparam logic [CW-1:0] TMO_C      = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_LAUNCH = 3'd2,
    S_RUN    = 3'd3,
    S_UNLOAD = 3'd4
  } state_e;

  state_e        state_q;
  logic [AW-1:0] idx_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cycles_q;
  logic          tmo_q;
  logic          done_q;
  logic          req_q;
  logic          busy_q;
  logic          ld_ready_q;
  logic          rs_valid_q;

  logic          done_rise;
  logic          idx_at_last;

  // A done level that was already high at LAUNCH is absorbed by done_q.
  assign done_rise   = done & ~done_q;
  assign idx_at_last = (idx_q == LAST_IDX_C);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      cycles_q   <= '0;
      tmo_q      <= 1'b0;
      done_q     <= 1'b0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      ld_ready_q <= 1'b0;
      rs_valid_q <= 1'b0;
    end else begin
      done_q <= done;
      req_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_LOAD;
            busy_q     <= 1'b1;
            ld_ready_q <= 1'b1;
            tmo_q      <= 1'b0;
            cnt_q      <= '0;
          end
        end
        S_LOAD: begin
          if (ld_valid && ld_last) begin
            state_q    <= S_LAUNCH;
            ld_ready_q <= 1'b0;
            req_q      <= 1'b1;
          end
        end
        S_LAUNCH: begin
          state_q <= S_RUN;
        end
        S_RUN: begin
          cnt_q <= cnt_q + CW'(1);
          // Completion takes priority over a coincident timeout.
          if (done_rise) begin
            cycles_q   <= cnt_q + CW'(1);
            state_q    <= S_UNLOAD;
            rs_valid_q <= 1'b1;
            idx_q      <= '0;
          end else if (cnt_q == TMO_C) begin
            tmo_q   <= 1'b1;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_UNLOAD: begin
          if (rs_ready) begin
            if (idx_at_last) begin
              state_q    <= S_IDLE;
              rs_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              idx_q      <= '0;
            end else begin
              idx_q <= idx_q + AW'(1);
            end
          end
        end
        default: begin
          state_q    <= S_IDLE;
          busy_q     <= 1'b0;
          ld_ready_q <= 1'b0;
          rs_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Load beats pass straight through so the write lands on the handshake edge.
  always_comb begin
    mem_wr_en  = 1'b0;
    mem_addr   = '0;
    mem_dat_in = '0;
    if (state_q == S_LOAD) begin
      mem_wr_en  = ld_valid;
      mem_addr   = ld_addr;
      mem_dat_in = ld_data;
    end else if (state_q == S_UNLOAD) begin
      mem_addr = BASE_C + idx_q;
    end
  end

  assign ld_ready    = ld_ready_q;
  assign req         = req_q;
  assign rs_valid    = rs_valid_q;
  assign rs_data     = rs_valid_q ? mem_dat_out : 8'h00;
  assign rs_last     = rs_valid_q & idx_at_last;
  assign busy        = busy_q;
  assign cycles      = cycles_q;
  assign timeout_err = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_core_launcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_launcher
// Purpose  : Directed scoreboard bench for core_launcher (two configurations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_launcher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, sel, ld_valid, ld_last, done, rs_ready;
  logic [7:0] ld_addr, ld_data;
  logic       start_a, start_b;

  logic        a_ld_ready, a_wr, a_req, a_rs_valid, a_rs_last, a_busy, a_tmo;
  logic [7:0]  a_addr, a_din, a_dout, a_rs_data;
  logic [15:0] a_cycles;
  logic        b_ld_ready, b_wr, b_req, b_rs_valid, b_rs_last, b_busy, b_tmo;
  logic [7:0]  b_addr, b_din, b_dout, b_rs_data;
  logic [15:0] b_cycles;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] ref_a [256];
  logic [7:0] ref_b [256];

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic       last;
  } beat_t;
  beat_t sb[$];

  int checks = 0;
  int errors = 0;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  core_launcher #(.AW(8), .RD_BASE(64), .RD_LEN(8), .CW(16), .TIMEOUT(20)) dut (
    .clk(clk), .reset(reset), .start(start_a),
    .ld_valid(ld_valid), .ld_ready(a_ld_ready), .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
    .mem_wr_en(a_wr), .mem_addr(a_addr), .mem_dat_in(a_din), .mem_dat_out(a_dout),
    .req(a_req), .done(done),
    .rs_valid(a_rs_valid), .rs_ready(rs_ready), .rs_data(a_rs_data), .rs_last(a_rs_last),
    .busy(a_busy), .cycles(a_cycles), .timeout_err(a_tmo)
  );

  core_launcher #(.AW(8), .RD_BASE(254), .RD_LEN(4), .CW(16), .TIMEOUT(50)) dut_wrap (
    .clk(clk), .reset(reset), .start(start_b),
    .ld_valid(ld_valid), .ld_ready(b_ld_ready), .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
    .mem_wr_en(b_wr), .mem_addr(b_addr), .mem_dat_in(b_din), .mem_dat_out(b_dout),
    .req(b_req), .done(done),
    .rs_valid(b_rs_valid), .rs_ready(rs_ready), .rs_data(b_rs_data), .rs_last(b_rs_last),
    .busy(b_busy), .cycles(b_cycles), .timeout_err(b_tmo)
  );

  always @(posedge clk) begin
    if (a_wr) mem_a[a_addr] <= a_din;
    if (b_wr) mem_b[b_addr] <= b_din;
  end
  assign a_dout = mem_a[a_addr];
  assign b_dout = mem_b[b_addr];

  logic        o_ld_ready, o_wr, o_req, o_rs_valid, o_rs_last, o_busy, o_tmo;
  logic [7:0]  o_addr, o_din, o_rs_data;
  logic [15:0] o_cycles;
  assign o_ld_ready = sel ? b_ld_ready : a_ld_ready;
  assign o_wr       = sel ? b_wr       : a_wr;
  assign o_req      = sel ? b_req      : a_req;
  assign o_rs_valid = sel ? b_rs_valid : a_rs_valid;
  assign o_rs_last  = sel ? b_rs_last  : a_rs_last;
  assign o_busy     = sel ? b_busy     : a_busy;
  assign o_tmo      = sel ? b_tmo      : a_tmo;
  assign o_addr     = sel ? b_addr     : a_addr;
  assign o_din      = sel ? b_din      : a_din;
  assign o_rs_data  = sel ? b_rs_data  : a_rs_data;
  assign o_cycles   = sel ? b_cycles   : a_cycles;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic begin_job();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ld_ready_after_start", o_ld_ready, 1);
    check("busy_after_start", o_busy, 1);
  endtask

  task automatic load_beat(input logic [7:0] addr, input logic [7:0] data, input logic last);
    ld_valid = 1'b1; ld_addr = addr; ld_data = data; ld_last = last;
    #1;
    check("ld_wr_en", o_wr, 1);
    check("ld_mem_addr", o_addr, addr);
    check("ld_mem_din", o_din, data);
    if (sel) ref_b[addr] = data; else ref_a[addr] = data;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic push_expect(input int base, input int len);
    beat_t e;
    for (int j = 0; j < len; j++) begin
      e.addr = 8'((base + j) % 256);
      e.data = sel ? ref_b[e.addr] : ref_a[e.addr];
      e.last = (j == len - 1);
      sb.push_back(e);
    end
  endtask

  // Entered in LAUNCH; raises done on RUN cycle k and checks the reported length.
  task automatic launch_and_run(input int k, input int base, input int len);
    done = 1'b0;
    check("req_in_launch", o_req, 1);
    tick();
    check("req_after_launch", o_req, 0);
    repeat (k - 1) tick();
    check("no_rs_before_done", o_rs_valid, 0);
    done = 1'b1;
    push_expect(base, len);
    tick();
    check("cycles", o_cycles, k);
  endtask

  task automatic unload(input logic [3:0] pat);
    int    c = 0;
    beat_t e;
    while (sb.size() > 0 && c < 64) begin
      rs_ready = pat[c % 4];
      #1;
      e = sb[0];
      check("rs_valid", o_rs_valid, 1);
      check("rs_addr", o_addr, e.addr);
      check("rs_data", o_rs_data, e.data);
      check("rs_last", o_rs_last, e.last);
      if (rs_ready) void'(sb.pop_front());
      c++;
      tick();
    end
    rs_ready = 1'b0;
    check("unload_drained", sb.size(), 0);
    check("busy_after_unload", o_busy, 0);
    check("rs_valid_after_unload", o_rs_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic seen_rs;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] <= 8'(i * 7 + 3);
      mem_b[i] <= 8'(~i);
      ref_a[i] = 8'(i * 7 + 3);
      ref_b[i] = 8'(~i);
    end
    reset = 1'b0; start = 1'b0; sel = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    done = 1'b0; rs_ready = 1'b0; ld_addr = 8'h00; ld_data = 8'h00;
    tick(); tick();
    reset = 1'b1;
    #1;
    check("rst_busy", o_busy, 0);
    check("rst_req", o_req, 0);
    check("rst_ld_ready", o_ld_ready, 0);
    check("rst_rs_valid", o_rs_valid, 0);
    check("rst_cycles", o_cycles, 0);
    check("rst_tmo", o_tmo, 0);

    // Reset during the second load beat.
    begin_job();
    load_beat(8'h10, 8'h11, 1'b0);
    ld_valid = 1'b1; ld_addr = 8'h11; ld_data = 8'h22;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("midrst_busy", o_busy, 0);
    check("midrst_wr_en", o_wr, 0);
    check("midrst_cycles", o_cycles, 0);
    ld_valid = 1'b0;
    tick();

    // Three-beat load, done on RUN cycle 10, full-rate unload of 64..71.
    begin_job();
    load_beat(8'h00, 8'hAA, 1'b0);
    load_beat(8'h01, 8'h55, 1'b0);
    load_beat(8'h02, 8'h0F, 1'b1);
    check("mem0", mem_a[0], 8'hAA);
    check("mem1", mem_a[1], 8'h55);
    check("mem2", mem_a[2], 8'h0F);
    launch_and_run(10, 64, 8);
    unload(4'b1111);

    // Backpressure pattern 1,0,0,1; first result byte overwritten by the load.
    begin_job();
    load_beat(8'd64, 8'hC3, 1'b1);
    launch_and_run(3, 64, 8);
    unload(4'b1001);

    // Timeout with done held low.
    done = 1'b0;
    begin_job();
    load_beat(8'h05, 8'h99, 1'b1);
    check("tmo_req", o_req, 1);
    tick();
    n = 0; seen_rs = 1'b0;
    while (o_busy && n < 40) begin
      if (o_rs_valid) seen_rs = 1'b1;
      n++;
      tick();
    end
    check("tmo_run_cycles", n, 21);
    check("tmo_flag", o_tmo, 1);
    check("tmo_cycles_kept", o_cycles, 3);
    check("tmo_no_rs", seen_rs, 0);
    begin_job();
    check("tmo_cleared", o_tmo, 0);
    load_beat(8'd65, 8'h3C, 1'b1);
    launch_and_run(1, 64, 8);
    unload(4'b1111);

    // Stale done through LAUNCH on the wrapping configuration.
    sel = 1'b1;
    done = 1'b1;
    begin_job();
    load_beat(8'd254, 8'h77, 1'b1);
    check("wrap_req", o_req, 1);
    tick();
    repeat (3) begin
      check("stale_busy", o_busy, 1);
      check("stale_no_rs", o_rs_valid, 0);
      tick();
    end
    done = 1'b0;
    tick(); tick();
    done = 1'b1;
    push_expect(254, 4);
    tick();
    check("wrap_cycles", o_cycles, 6);
    unload(4'b1111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/core_launcher.md
# core_launcher

Host-side job sequencer that sits directly upstream of the single-cycle core's top level. It streams a byte image from a host into the core's data memory, then pulses the core's `req`. It waits for the core's `done` and streams a fixed window of result bytes back out of data memory. It also reports the run's cycle count and a timeout flag.

## Interface
Parameters:
- `AW`, default 8: data-memory address width.
- `RD_BASE`, default 8'd64: first result address unloaded.
- `RD_LEN`, default 8: number of result bytes unloaded, 1..2^AW.
- `CW`, default 16: cycle-counter width.
- `TIMEOUT`, default 4095: maximum RUN cycles before abort; must be less than 2^CW.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  begin job; sampled in IDLE only.
- `ld_valid`  in  1  load beat valid.
- `ld_ready`  out  1  load beat accepted.
- `ld_addr`  in  AW  load byte address.
- `ld_data`  in  8  load byte.
- `ld_last`  in  1  final load beat.
- `mem_wr_en`  out  1  data-memory write strobe.
- `mem_addr`  out  AW  data-memory address.
- `mem_dat_in`  out  8  data-memory write data.
- `mem_dat_out`  in  8  data-memory read data; combinational read of `mem_addr`.
- `req`  out  1  one-cycle launch pulse to core.
- `done`  in  1  core completion level.
- `rs_valid`  out  1  result beat valid.
- `rs_ready`  in  1  result beat accepted.
- `rs_data`  out  8  result byte.
- `rs_last`  out  1  final result beat.
- `busy`  out  1  high in every state but IDLE.
- `cycles`  out  CW  RUN length of the last completed job.
- `timeout_err`  out  1  last job aborted on timeout.

## Operation
- States: IDLE, LOAD, LAUNCH, RUN, UNLOAD.
- IDLE:
  - Outputs `ld_ready`, `rs_valid`, `req` and `mem_wr_en` are all 0.
  - `start`=1 moves to LOAD, clears `timeout_err` and clears the internal run counter.
- LOAD:
  - `ld_ready`=1.
  - `mem_wr_en`=`ld_valid`, `mem_addr`=`ld_addr`, `mem_dat_in`=`ld_data`. All are combinational pass-through, so the write lands on the handshake edge.
  - A handshake with `ld_last`=1 moves to LAUNCH.
  - Zero-beat loads are impossible; the host sends at least one beat.
- LAUNCH:
  - `req`=1 for exactly this one cycle, then RUN.
  - `done_q` (registered `done`) is loaded with the current `done`, so a `done` level left over from a previous run is not an edge.
- RUN:
  - The run counter increments each cycle.
  - Completion is the rising edge `done & ~done_q`. On completion, `cycles` is set to counter+1, and the state moves to UNLOAD.
  - If the counter equals `TIMEOUT` without an edge, the block sets `timeout_err`=1, leaves `cycles` unchanged and moves to IDLE. No unload occurs.
  - If an edge arrives in the same cycle as the timeout, the edge wins.
- UNLOAD:
  - Index `idx` starts at 0.
  - `mem_addr` = `RD_BASE`+`idx`, truncated to AW (wraps mod 2^AW).
  - `rs_valid`=1, `rs_data`=`mem_dat_out`, `rs_last`=(`idx`==`RD_LEN`-1).
  - On each `rs_valid`&`rs_ready`, `idx` increments.
  - The handshake on the last beat moves to IDLE.
  - `rs_data` and `rs_last` stay stable while `rs_valid`=1 and `rs_ready`=0.
- `mem_addr` and `mem_dat_in` are 0 in IDLE, LAUNCH and RUN.
- `start` outside IDLE is ignored.
- `done` outside RUN affects nothing except `done_q` tracking.

## Timing
- Reset, while `reset`=0 at a clock edge:
  - State becomes IDLE.
  - `busy`, `req`, `ld_ready`, `rs_valid`, `rs_last` and `mem_wr_en` are 0.
  - `cycles`=0, `timeout_err`=0, `idx`=0, `done_q`=0.
- A reset asserted mid-LOAD or mid-UNLOAD aborts immediately. No write strobe is issued in the cycle after reset.
- Latencies:
  - `start` to `ld_ready`: 1 cycle.
  - Last load handshake to `req`: 1 cycle.
  - `req` to the first RUN cycle: 1 cycle.
  - `done` edge to `rs_valid`: 1 cycle.
- Unload throughput is 1 byte per cycle when `rs_ready` is held at 1.
- `cycles` and `timeout_err` only change at the points listed in Operation, and hold otherwise.

## Test plan
- Reset mid-job: reset low for 1 cycle during LOAD beat 2 -> next cycle IDLE, `busy`=0, `mem_wr_en`=0, `cycles`=0.
- Load/launch:
  - Stimulus: `start`, then 3 beats (addr 0x00/0x01/0x02, data 0xAA/0x55/0x0F, last on the 3rd).
  - Required: 3 writes with `mem_wr_en`=1 on those addresses; `req` high for exactly 1 cycle, 1 cycle after the 3rd beat.
- Run and unload:
  - Stimulus: model core raises `done` on RUN cycle 10; `rs_ready`=1.
  - Required: `cycles`=10; 8 beats read from addresses 64..71 with `rs_last` only on beat 8; `busy` falls 1 cycle after beat 8.
- Backpressure: `rs_ready` toggles 1,0,0,1 -> `rs_data`/`mem_addr` held during stalls; no byte skipped or repeated.
- Timeout:
  - Stimulus: `TIMEOUT`=20 with `done` held low.
  - Required: IDLE after 21 RUN cycles, `timeout_err`=1, `cycles` keeps its prior value, no `rs_valid`.
  - Stimulus: next `start`. Required: `timeout_err` clears.
- Stale done and wrap:
  - Stimulus: `done` held high through LAUNCH.
  - Required: no completion until `done` falls and rises again.
  - Stimulus: `RD_BASE`=254, `RD_LEN`=4. Required: addresses 254, 255, 0, 1.
